// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-wide system bus initiator for fetch and load/store ports.
// Splits word/half/byte requests into pipelined single-byte transactions.
module mem_ctrl #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rdy,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  input  logic                  if_abort,
  output logic                  if_done,
  output logic [31:0]           if_data,
  input  logic                  ls_req,
  input  logic                  ls_wr,
  input  logic [1:0]            ls_size,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic [31:0]           ls_wdata,
  output logic                  ls_done,
  output logic [31:0]           ls_rdata,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;

  logic [1:0]            state_q;
  logic                  fetch_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [1:0]            last_q;
  logic [2:0]            iss_q;
  logic [1:0]            cap_q;
  logic                  pend_q;
  logic [31:0]           buf_q;
  logic [23:0]           wdata_q;
  logic                  wr_q;
  logic [31:0]           rd_merged;

  assign mem_wr = wr_q & rdy;

  always_comb begin
    rd_merged = buf_q;
    rd_merged[{cap_q, 3'b000} +: 8] = mem_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      fetch_q  <= 1'b0;
      base_q   <= '0;
      last_q   <= 2'd0;
      iss_q    <= 3'd0;
      cap_q    <= 2'd0;
      pend_q   <= 1'b0;
      buf_q    <= 32'd0;
      wdata_q  <= 24'd0;
      wr_q     <= 1'b0;
      mem_a    <= '0;
      mem_dout <= 8'd0;
      if_done  <= 1'b0;
      if_data  <= 32'd0;
      ls_done  <= 1'b0;
      ls_rdata <= 32'd0;
    end else begin
      if_done <= 1'b0;
      ls_done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (rdy && !if_done && !ls_done) begin
            if (ls_req) begin
              fetch_q <= 1'b0;
              base_q  <= ls_addr;
              mem_a   <= ls_addr;
              last_q  <= ls_size[1] ? 2'd3 : {1'b0, ls_size[0]};
              iss_q   <= 3'd0;
              cap_q   <= 2'd0;
              pend_q  <= 1'b0;
              buf_q   <= 32'd0;
              if (ls_wr) begin
                state_q  <= WRITE;
                wr_q     <= 1'b1;
                mem_dout <= ls_wdata[7:0];
                wdata_q  <= ls_wdata[31:8];
              end else begin
                state_q <= READ;
              end
            end else if (if_req) begin
              fetch_q <= 1'b1;
              base_q  <= if_addr;
              mem_a   <= if_addr;
              last_q  <= 2'd3;
              iss_q   <= 3'd0;
              cap_q   <= 2'd0;
              pend_q  <= 1'b0;
              buf_q   <= 32'd0;
              state_q <= READ;
            end
          end
        end
        READ: begin
          if (!rdy) begin
            // In-flight byte is lost; replay from the oldest uncaptured one.
            iss_q  <= {1'b0, cap_q};
            pend_q <= 1'b0;
            mem_a  <= base_q + ADDR_WIDTH'(cap_q);
          end else if (fetch_q && if_abort) begin
            state_q <= IDLE;
            pend_q  <= 1'b0;
          end else begin
            if (pend_q) begin
              buf_q <= rd_merged;
              cap_q <= cap_q + 2'd1;
              if (cap_q == last_q) begin
                state_q <= IDLE;
                if (fetch_q) begin
                  if_done <= 1'b1;
                  if_data <= rd_merged;
                end else begin
                  ls_done  <= 1'b1;
                  ls_rdata <= rd_merged;
                end
              end
            end
            if (iss_q <= {1'b0, last_q}) begin
              pend_q <= 1'b1;
              iss_q  <= iss_q + 3'd1;
              if (iss_q < {1'b0, last_q})
                mem_a <= base_q + ADDR_WIDTH'(iss_q + 3'd1);
            end else begin
              pend_q <= 1'b0;
            end
          end
        end
        WRITE: begin
          if (rdy) begin
            if (iss_q[1:0] == last_q) begin
              state_q  <= IDLE;
              wr_q     <= 1'b0;
              mem_dout <= 8'd0;
              ls_done  <= 1'b1;
            end else begin
              iss_q    <= iss_q + 3'd1;
              mem_a    <= base_q + ADDR_WIDTH'(iss_q + 3'd1);
              mem_dout <= wdata_q[7:0];
              wdata_q  <= {8'd0, wdata_q[23:8]};
            end
          end
        end
        default: begin
          state_q <= IDLE;
          wr_q    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- CPU-side initiator for the byte-wide system memory bus (mem_a, mem_dout, mem_din, mem_wr), which is served by the internal RAM and the memory-mapped HCI I/O window.
- Turns 32-bit instruction-fetch requests and 1/2/4-byte load/store requests into sequences of single-byte bus transactions.
- Arbitrates between the two request ports and honours the global rdy stall.

Parameters:
- ADDR_WIDTH, 32, width of request and bus addresses.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- rdy  in  1  1 = bus owned by CPU; 0 = paused (HCI debug break)
- if_req  in  1  fetch request, level, held until if_done
- if_addr  in  32  fetch byte address
- if_abort  in  1  cancel in-flight fetch (branch redirect)
- if_done  out  1  one-cycle pulse, fetch complete
- if_data  out  32  fetched word, little-endian
- ls_req  in  1  load/store request, level, held until ls_done
- ls_wr  in  1  1 = store, 0 = load
- ls_size  in  2  00 = byte, 01 = half, 10/11 = word
- ls_addr  in  32  byte address, no alignment required
- ls_wdata  in  32  store data, low bytes used
- ls_done  out  1  one-cycle pulse, access complete
- ls_rdata  out  32  load data, zero-extended
- mem_din  in  8  read byte, valid the cycle after its address
- mem_dout  out  8  write byte
- mem_a  out  32  bus byte address
- mem_wr  out  1  1 = write this cycle

Behaviour:
- Reset (rst_n = 0, async): state IDLE; all outputs 0; internal indices cleared.
- States: IDLE, READ, WRITE.
- IDLE arbitration at a rising edge (only when if_done and ls_done are both low):
  - ls_req has priority. ls_wr = 1 goes to WRITE, otherwise READ.
  - Else if_req goes to READ as a word access.
  - Else remain in IDLE.
- Byte count N: 1, 2 or 4 (fetch is always 4). Byte k is at address A + k, using 32-bit wrap-around (0xFFFFFFFF + 1 = 0). Byte k occupies data bits [8k+7:8k].
- Timing, with acceptance at edge E0 and cycle j being the cycle after edge E(j-1):
  - READ: mem_a = A + k in cycle k + 1. mem_din captured at edge E(k+2). done is high in cycle N + 2. A word read has done high in cycle 6. Addresses are never issued beyond A + N - 1.
  - WRITE: mem_a = A + k, mem_dout = byte k, mem_wr = 1 in cycle k + 1. done is high in cycle N + 1.
- done is a single-cycle pulse; the FSM is back in IDLE during that cycle. if_data / ls_rdata change only at done and hold until the next done on the same port. Requesters drop req in the done cycle.
- Outside WRITE, mem_wr = 0 and mem_dout = 0. In IDLE, mem_a holds its last value.
- Stall (rdy = 0):
  - mem_wr is gated to 0 combinationally. No index advances, no capture occurs, state is frozen.
  - A read byte is captured only if rdy was 1 in both its address cycle and its capture cycle.
  - On the first rdy = 1 cycle after a stall, the issue index is reset to the oldest un-captured/un-written byte and that address is re-driven. Pipelining then resumes.
  - Re-reads of I/O addresses during replay are accepted behaviour.
- if_abort:
  - Sampled high at an edge while a fetch is in READ: next state IDLE, no if_done, if_data unchanged.
  - Ignored in IDLE and during load/store transactions.
  - If it coincides with the if_done cycle, the done stands.
- ls_rdata bits above 8N read 0. ls_wdata bits above 8N are ignored.
- Reset asserted mid-transaction: the transaction is abandoned immediately, outputs return to 0, and no done is issued.

Test Plan:
- Word load: ls_req=1, ls_wr=0, ls_size=10, ls_addr=0x100, RAM bytes 0x100..0x103 = 78 56 34 12 -> mem_a = 0x100..0x103 in cycles 1-4; ls_done in cycle 6; ls_rdata = 0x12345678.
- Half store: ls_wr=1, ls_size=01, ls_addr=0x30001, ls_wdata=0xAABBCCDD -> two cycles with mem_wr=1 (0x30001 <- DD, 0x30002 <- CC); ls_done in cycle 3; no further writes.
- Arbitration: if_req and ls_req (byte load at 0x8) raised together -> load served first (ls_done cycle 3, ls_rdata = 0x000000xx); fetch accepted after the dead cycle; if_done follows 6 cycles later.
- Stall: word fetch at 0x0 with rdy=0 for 3 cycles after byte 1 is issued -> mem_wr stays 0; byte 1 address re-driven on resume; if_data correct; if_done delayed by 3 + 1 replay cycles.
- Abort: fetch at 0x40, if_abort pulsed in cycle 3 -> no if_done; FSM idle next cycle; a subsequent fetch at 0x80 returns the correct word.
- Wrap/reset: byte... word load at 0xFFFFFFFE -> mem_a = FFFFFFFE, FFFFFFFF, 0, 1. Then rst_n low mid-store -> mem_wr = 0 immediately, no ls_done.
